// File: rtl/rps_pkg.sv
// Shared types and move helpers for the rock-paper-scissors match controller.
// The forfeit timeout in rps_match_ctrl is enabled by defining RPS_TIMEOUT_EN.
package rps_pkg;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    ROCK     = 3'd1,
    PAPER    = 3'd2,
    SCISSORS = 3'd3,
    INVALID  = 3'd4
  } move_t;

  typedef enum logic [1:0] {
    TIE  = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    VOID = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    JUDGE   = 2'd1,
    REPORT  = 2'd2,
    DONE    = 2'd3
  } ctrl_state_t;

  function automatic move_t encode_move(input logic r, input logic p, input logic s);
    move_t m;
    case ({r, p, s})
      3'b100:  m = ROCK;
      3'b010:  m = PAPER;
      3'b001:  m = SCISSORS;
      3'b000:  m = NONE;
      default: m = INVALID;
    endcase
    return m;
  endfunction

  function automatic logic move_beats(input move_t a, input move_t b);
    return ((a == ROCK) && (b == SCISSORS)) ||
           ((a == SCISSORS) && (b == PAPER)) ||
           ((a == PAPER) && (b == ROCK));
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational comparator: a pair of latched moves to a round result.
// Anything other than a clean rock/paper/scissors on either side voids the round.
module rps_judge
  import rps_pkg::*;
(
  input  move_t   move1,
  input  move_t   move2,
  output result_t result
);

  logic valid1_s;
  logic valid2_s;

  assign valid1_s = (move1 == ROCK) || (move1 == PAPER) || (move1 == SCISSORS);
  assign valid2_s = (move2 == ROCK) || (move2 == PAPER) || (move2 == SCISSORS);

  // Rank the two moves
  always_comb begin
    result = VOID;
    if (!valid1_s || !valid2_s) begin
      result = VOID;
    end else if (move1 == move2) begin
      result = TIE;
    end else if (move_beats(move1, move2)) begin
      result = P1;
    end else begin
      result = P2;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: collects both moves, judges, reports and keeps score to WIN_TARGET.
// Define RPS_TIMEOUT_EN to let a lone latched player win by forfeit after TIMEOUT_CYCLES.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int SCORE_W        = 8,
  parameter int WIN_TARGET     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r1,
  input  logic               p1,
  input  logic               s1,
  input  logic               r2,
  input  logic               p2,
  input  logic               s2,
  input  logic               go1,
  input  logic               go2,
  input  logic               new_match,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               dut_busy,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic               match_done,
  output logic [1:0]         match_winner
);

  localparam logic [SCORE_W-1:0] TARGET_C    = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] SCORE_ONE_C = SCORE_W'(1'b1);

  ctrl_state_t        state_r, state_next_s;
  logic               lat1_r, lat2_r;
  move_t              move1_r, move2_r;
  logic               forfeit_r;
  logic               timeout_hit_s;
  result_t            judge_result_s, round_result_s;
  logic [SCORE_W-1:0] score1_r, score2_r;
  logic               busy_r, round_valid_r, match_done_r;
  result_t            round_result_r;
  logic [1:0]         match_winner_r;

  rps_judge u_judge (
    .move1  (move1_r),
    .move2  (move2_r),
    .result (judge_result_s)
  );

`ifdef RPS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE_C  = TMO_W'(1'b1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             waiting_s;

  // Exactly one side latched and the other side still silent this cycle
  assign waiting_s = (lat1_r & ~lat2_r & ~go2) | (lat2_r & ~lat1_r & ~go1);
  assign timeout_hit_s = (state_r == COLLECT) && waiting_s && (tmo_cnt_r == TMO_LAST_C);

  // Forfeit timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == COLLECT) && waiting_s && !timeout_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE_C;
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Forfeit overrides the comparator and credits whoever did move
  always_comb begin
    round_result_s = judge_result_s;
    if (forfeit_r) begin
      if (lat1_r) begin
        round_result_s = P1;
      end else begin
        round_result_s = P2;
      end
    end else begin
      round_result_s = judge_result_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      COLLECT: begin
        if (((lat1_r | go1) && (lat2_r | go2)) || timeout_hit_s) begin
          state_next_s = JUDGE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      JUDGE:   state_next_s = REPORT;
      REPORT: begin
        if ((score1_r == TARGET_C) || (score2_r == TARGET_C)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      DONE: begin
        if (new_match) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = COLLECT;
    endcase
  end

  // State, move latches, scores and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= COLLECT;
      lat1_r         <= 1'b0;
      lat2_r         <= 1'b0;
      move1_r        <= NONE;
      move2_r        <= NONE;
      forfeit_r      <= 1'b0;
      score1_r       <= '0;
      score2_r       <= '0;
      busy_r         <= 1'b0;
      round_valid_r  <= 1'b0;
      round_result_r <= TIE;
      match_done_r   <= 1'b0;
      match_winner_r <= 2'b00;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= (state_next_s != COLLECT);
      round_valid_r <= 1'b0;
      case (state_r)
        COLLECT: begin
          if (go1 && !lat1_r) begin
            lat1_r  <= 1'b1;
            move1_r <= encode_move(r1, p1, s1);
          end
          if (go2 && !lat2_r) begin
            lat2_r  <= 1'b1;
            move2_r <= encode_move(r2, p2, s2);
          end
          forfeit_r <= timeout_hit_s;
        end
        JUDGE: begin
          round_valid_r  <= 1'b1;
          round_result_r <= round_result_s;
          if ((round_result_s == P1) && (score1_r < TARGET_C)) begin
            score1_r <= score1_r + SCORE_ONE_C;
          end else if ((round_result_s == P2) && (score2_r < TARGET_C)) begin
            score2_r <= score2_r + SCORE_ONE_C;
          end
        end
        REPORT: begin
          lat1_r    <= 1'b0;
          lat2_r    <= 1'b0;
          forfeit_r <= 1'b0;
          if (state_next_s == DONE) begin
            match_done_r   <= 1'b1;
            match_winner_r <= (score1_r == TARGET_C) ? 2'b01 : 2'b10;
          end
        end
        DONE: begin
          if (new_match) begin
            score1_r       <= '0;
            score2_r       <= '0;
            match_done_r   <= 1'b0;
            match_winner_r <= 2'b00;
          end
        end
        default: begin
          lat1_r <= 1'b0;
          lat2_r <= 1'b0;
        end
      endcase
    end
  end

  assign score1       = score1_r;
  assign score2       = score2_r;
  assign dut_busy     = busy_r;
  assign round_valid  = round_valid_r;
  assign round_result = round_result_r;
  assign match_done   = match_done_r;
  assign match_winner = match_winner_r;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl: table of single rounds plus hand-written corner sequences.
module tb_rps_match_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       r1, p1, s1, r2, p2, s2, go1, go2, new_match;
  logic [7:0] score1, score2;
  logic       dut_busy, round_valid, match_done;
  logic [1:0] round_result, match_winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rps_match_ctrl #(
    .SCORE_W        (8),
    .WIN_TARGET     (3),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .r1           (r1),
    .p1           (p1),
    .s1           (s1),
    .r2           (r2),
    .p2           (p2),
    .s2           (s2),
    .go1          (go1),
    .go2          (go2),
    .new_match    (new_match),
    .score1       (score1),
    .score2       (score2),
    .dut_busy     (dut_busy),
    .round_valid  (round_valid),
    .round_result (round_result),
    .match_done   (match_done),
    .match_winner (match_winner)
  );

  typedef struct {
    logic       r1, p1, s1, r2, p2, s2;
    logic [1:0] res;
    logic [7:0] sc1, sc2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {r1, p1, s1, r2, p2, s2, go1, go2, new_match} = 9'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Both players move on the same edge; check busy, report cycle, return to COLLECT
  task automatic play(input vec_t v, input string tag);
    {r1, p1, s1} = {v.r1, v.p1, v.s1};
    {r2, p2, s2} = {v.r2, v.p2, v.s2};
    go1 = 1'b1;
    go2 = 1'b1;
    step();
    clear_in();
    chk({tag, " busy_judge"}, 32'(dut_busy), 32'd1);
    chk({tag, " no_early_valid"}, 32'(round_valid), 32'd0);
    step();
    chk({tag, " round_valid"}, 32'(round_valid), 32'd1);
    chk({tag, " result"}, 32'(round_result), 32'(v.res));
    chk({tag, " score1"}, 32'(score1), 32'(v.sc1));
    chk({tag, " score2"}, 32'(score2), 32'(v.sc2));
    step();
    chk({tag, " valid_pulse_end"}, 32'(round_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    int waited;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'd1, 8'd0}; // rock beats scissors
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'd1, 8'd0}; // multi-hot voids
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd1, 8'd0}; // paper tie
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'd1, 8'd1}; // rock beats scissors (p2)
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 8'd1, 8'd1}; // empty move voids
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'd1, 8'd2}; // scissors beats paper
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 8'd2, 8'd2}; // scissors beats paper (p1)
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd2, 8'd2}; // rock tie

    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst score1", 32'(score1), 32'd0);
    chk("rst score2", 32'(score2), 32'd0);
    chk("rst busy", 32'(dut_busy), 32'd0);
    chk("rst valid", 32'(round_valid), 32'd0);
    chk("rst result", 32'(round_result), 32'd0);
    chk("rst done", 32'(match_done), 32'd0);
    chk("rst winner", 32'(match_winner), 32'd0);

    for (int i = 0; i < 8; i++) begin
      play(vecs[i], $sformatf("vec%0d", i));
    end

    // Staggered moves with a repeated go1 that must be ignored
    do_reset();
    p1 = 1'b1; go1 = 1'b1;
    step(); clear_in();
    chk("stagger busy e1", 32'(dut_busy), 32'd0);
    step();
    chk("stagger busy e2", 32'(dut_busy), 32'd0);
    r1 = 1'b1; go1 = 1'b1;
    step(); clear_in();
    chk("stagger busy e3", 32'(dut_busy), 32'd0);
    step();
    chk("stagger busy e4", 32'(dut_busy), 32'd0);
    p2 = 1'b1; go2 = 1'b1;
    step(); clear_in();
    chk("stagger busy e5", 32'(dut_busy), 32'd1);
    step();
    chk("stagger valid", 32'(round_valid), 32'd1);
    chk("stagger result", 32'(round_result), 32'd0);
    chk("stagger scores", 32'({score1, score2}), 32'd0);

    // Reset while in JUDGE wipes the round and the score
    do_reset();
    play(vecs[0], "pre_rst");
    r1 = 1'b1; s2 = 1'b1; go1 = 1'b1; go2 = 1'b1;
    step(); clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst score1", 32'(score1), 32'd0);
    chk("midrst busy", 32'(dut_busy), 32'd0);
    chk("midrst valid", 32'(round_valid), 32'd0);
    chk("midrst result", 32'(round_result), 32'd0);
    step();
    chk("midrst no_pulse", 32'(round_valid), 32'd0);
    // Moves presented on a reset edge are dropped
    rst = 1'b1; r1 = 1'b1; s2 = 1'b1; go1 = 1'b1; go2 = 1'b1;
    step();
    rst = 1'b0; clear_in();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstgo valid%0d", i), 32'(round_valid), 32'd0);
      chk($sformatf("rstgo busy%0d", i), 32'(dut_busy), 32'd0);
      step();
    end

    // Player 2 wins a full match
    do_reset();
    play('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'd0, 8'd1}, "m1");
    new_match = 1'b1;
    step(); clear_in();
    chk("newmatch_ignored score2", 32'(score2), 32'd1);
    play('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'd0, 8'd2}, "m2");
    play('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'd0, 8'd3}, "m3");
    chk("done flag", 32'(match_done), 32'd1);
    chk("done winner", 32'(match_winner), 32'd2);
    chk("done busy", 32'(dut_busy), 32'd1);
    r1 = 1'b1; s2 = 1'b1; go1 = 1'b1; go2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("done_ignore valid%0d", i), 32'(round_valid), 32'd0);
      chk($sformatf("done_ignore scores%0d", i), 32'({score1, score2}), 32'h0003);
    end
    clear_in();
    new_match = 1'b1;
    step(); clear_in();
    chk("new_match scores", 32'({score1, score2}), 32'd0);
    chk("new_match done", 32'(match_done), 32'd0);
    chk("new_match winner", 32'(match_winner), 32'd0);
    chk("new_match busy", 32'(dut_busy), 32'd0);
    play(vecs[0], "after_new");

    // Lone player: forfeit win with the timeout, endless wait without it
    do_reset();
    s1 = 1'b1; go1 = 1'b1;
    step(); clear_in();
    seen = 1'b0;
    waited = 0;
`ifdef RPS_TIMEOUT_EN
    while (!seen && waited < 20) begin
      step();
      waited++;
      if (round_valid) seen = 1'b1;
    end
    chk("forfeit seen", 32'(seen), 32'd1);
    chk("forfeit latency", 32'(waited), 32'd5);
    chk("forfeit result", 32'(round_result), 32'd1);
    chk("forfeit score1", 32'(score1), 32'd1);
`else
    while (waited < 100) begin
      step();
      waited++;
      if (round_valid) seen = 1'b1;
    end
    chk("no_timeout valid", 32'(seen), 32'd0);
    chk("no_timeout busy", 32'(dut_busy), 32'd0);
    chk("no_timeout score1", 32'(score1), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
